// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg
// Shared types and constants for the MIPS memory-bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, FETCH, DATA, RESP)
//   BE_WORD     : full-word byte-enable pattern used by instruction fetch
//   BUS_AW      : bus address width
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam int         BUS_AW  = 32;

endpackage

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Shares one Avalon-style memory master between the instruction-fetch and
// the data load/store requesters. Each transaction runs grant -> transfer ->
// one-cycle response, and a saturating starvation counter bounds how many
// data grants may overtake a pending fetch.
//
// Ports
//   clk, reset             : clock, synchronous active-low reset
//   i_req, i_addr          : fetch request / byte address
//   i_done, i_rdata        : fetch completion pulse / fetched word (held)
//   d_req, d_write, d_addr : data request, store flag, byte address
//   d_wdata, d_byteenable  : store data / byte lanes
//   d_done, d_rdata        : data completion pulse / load word (held)
//   address, read, write   : bus address (word aligned) and strobes
//   byteenable, writedata  : bus byte lanes and write data
//   readdata, waitrequest  : bus read data and stall
//   busy                   : arbiter not in IDLE
import mips_bus_pkg::*;

module mips_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [BUS_AW-1:0]   i_addr,
  output logic                i_done,
  output logic [31:0]         i_rdata,
  input  logic                d_req,
  input  logic                d_write,
  input  logic [BUS_AW-1:0]   d_addr,
  input  logic [31:0]         d_wdata,
  input  logic [3:0]          d_byteenable,
  output logic                d_done,
  output logic [31:0]         d_rdata,
  output logic [BUS_AW-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [3:0]          byteenable,
  output logic [31:0]         writedata,
  input  logic [31:0]         readdata,
  input  logic                waitrequest,
  output logic                busy
);

  // Counter is at least one bit wide so STARVE_MAX=0 still elaborates.
  localparam int unsigned     SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t          state_q, state_d;
  logic                src_data_q, src_data_d;   // 1 = last transfer was data
  logic [BUS_AW-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         i_rdata_q, i_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic [SW-1:0]       starve_q, starve_d;

  // Byte-offset bits are architecturally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    src_data_d = src_data_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    starve_d   = starve_q;

    case (state_q)
      IDLE: begin
        // Data wins unless fetch is pending and data has already overtaken
        // it STARVE_MAX times in a row.
        if (d_req && (!i_req || (starve_q < STARVE_LIM))) begin
          state_d = DATA;
          addr_d  = {d_addr[BUS_AW-1:2], 2'b00};
          wr_d    = d_write;
          wdata_d = d_wdata;
          be_d    = d_byteenable;
          if (i_req) begin
            // starve_q < STARVE_LIM here, so the increment saturates naturally.
            starve_d = starve_q + SW'(1);
          end
        end else if (i_req) begin
          state_d  = FETCH;
          addr_d   = {i_addr[BUS_AW-1:2], 2'b00};
          starve_d = '0;
        end
      end
      FETCH: begin
        if (!waitrequest) begin
          i_rdata_d  = readdata;
          src_data_d = 1'b0;
          state_d    = RESP;
        end
      end
      DATA: begin
        if (!waitrequest) begin
          if (!wr_q) begin
            d_rdata_d = readdata;
          end
          src_data_d = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      src_data_q <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      src_data_q <= src_data_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      starve_q   <= starve_d;
    end
  end

  // All outputs decode registered state only.
  assign read       = (state_q == FETCH) || ((state_q == DATA) && !wr_q);
  assign write      = (state_q == DATA) && wr_q;
  assign byteenable = (state_q == FETCH) ? BE_WORD :
                      (state_q == DATA)  ? be_q    : 4'b0000;
  assign address    = addr_q;
  assign writedata  = wdata_q;
  assign i_done     = (state_q == RESP) && !src_data_q;
  assign d_done     = (state_q == RESP) && src_data_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
module tb_mips_mem_arbiter;

  localparam int SMAX = 2;

  logic        clk;
  logic        reset, reset0;
  logic        i_req, d_req, d_write, waitrequest;
  logic [31:0] i_addr, d_addr, d_wdata, readdata;
  logic [3:0]  d_byteenable;

  logic        i_done, d_done, rd, wr, busy;
  logic [31:0] i_rdata, d_rdata, address, writedata;
  logic [3:0]  byteenable;

  logic        i_done_z, d_done_z, rd_z, wr_z, busy_z;
  logic [31:0] i_rdata_z, d_rdata_z, address_z, writedata_z;
  logic [3:0]  byteenable_z;

  mips_mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_done(d_done), .d_rdata(d_rdata),
    .address(address), .read(rd), .write(wr), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .busy(busy)
  );

  mips_mem_arbiter #(.STARVE_MAX(0)) dut0 (
    .clk(clk), .reset(reset0),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done_z), .i_rdata(i_rdata_z),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_done(d_done_z), .d_rdata(d_rdata_z),
    .address(address_z), .read(rd_z), .write(wr_z), .byteenable(byteenable_z),
    .writedata(writedata_z), .readdata(readdata), .waitrequest(waitrequest),
    .busy(busy_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: transaction phase (0 idle, 1 bus transfer, 2 response),
  // the granted transaction, the overtake count and the word memory.
  int          mphase, msrc, mk;
  logic [31:0] x_addr, x_wdata;
  logic        x_wr;
  logic [3:0]  x_be;
  logic [31:0] exp_ir, exp_dr;
  logic [31:0] mem [256];
  int          req_mode;    // 0 random, 1 always re-request, 2 manual
  int          force_wait;
  bit          rand_wait;
  int          obs[$];      // observed completion order: 0 fetch, 1 data

  task automatic new_fetch();
    i_addr = $urandom;
  endtask

  task automatic new_data();
    d_write      = 1'($urandom_range(0, 1));
    d_addr       = $urandom;
    d_wdata      = $urandom;
    d_byteenable = 4'($urandom);
  endtask

  // Called once per cycle at the falling edge: check this cycle's outputs,
  // then drive inputs for the next rising edge and advance the model.
  task automatic cycle();
    bit jd_i, jd_d;
    chk("busy", busy, mphase != 0);
    if (mphase == 1) begin
      chk("read", rd, (msrc == 0) || !x_wr);
      chk("write", wr, (msrc == 1) && x_wr);
      chk("byteenable", byteenable, (msrc == 0) ? 4'hF : x_be);
      chk("address", address, x_addr);
      if (msrc == 1 && x_wr) chk("writedata", writedata, x_wdata);
    end else begin
      chk("read_off", rd, 0);
      chk("write_off", wr, 0);
      chk("be_off", byteenable, 0);
    end
    chk("i_done", i_done, (mphase == 2) && (msrc == 0));
    chk("d_done", d_done, (mphase == 2) && (msrc == 1));
    chk("i_rdata", i_rdata, exp_ir);
    chk("d_rdata", d_rdata, exp_dr);
    if (i_done) obs.push_back(0);
    if (d_done) obs.push_back(1);

    // Memory slave
    if (mphase == 1 && force_wait > 0) begin
      waitrequest = 1'b1;
      force_wait--;
    end else if (rand_wait) begin
      waitrequest = ($urandom_range(0, 2) == 0);
    end else begin
      waitrequest = 1'b0;
    end
    readdata = (mphase == 1) ? mem[address[9:2]] : $urandom;

    // Requesters drop after their done pulse, never re-raising that same cycle.
    jd_i = 1'b0;
    jd_d = 1'b0;
    if (mphase == 2 && msrc == 0) begin i_req = 1'b0; jd_i = 1'b1; end
    if (mphase == 2 && msrc == 1) begin d_req = 1'b0; jd_d = 1'b1; end
    if (req_mode == 1) begin
      if (!i_req && !jd_i) begin i_req = 1'b1; new_fetch(); end
      if (!d_req && !jd_d) begin d_req = 1'b1; new_data(); end
    end else if (req_mode == 0) begin
      if (!i_req && !jd_i && $urandom_range(0, 2) == 0) begin i_req = 1'b1; new_fetch(); end
      if (!d_req && !jd_d && $urandom_range(0, 2) == 0) begin d_req = 1'b1; new_data(); end
      // Disturb the granted requester's inputs; the transfer must use latched values.
      if (mphase == 1 && $urandom_range(0, 3) == 0) begin
        if (msrc == 0) new_fetch(); else new_data();
      end
    end

    // Model advance for the coming rising edge
    if (!reset) begin
      mphase = 0; mk = 0; exp_ir = '0; exp_dr = '0;
    end else begin
      case (mphase)
        0: begin
          if (d_req && (!i_req || mk < SMAX)) begin
            msrc = 1; x_addr = {d_addr[31:2], 2'b00}; x_wr = d_write;
            x_wdata = d_wdata; x_be = d_byteenable;
            if (i_req) mk = mk + 1;
            mphase = 1;
          end else if (i_req) begin
            msrc = 0; x_addr = {i_addr[31:2], 2'b00}; mk = 0;
            mphase = 1;
          end
        end
        1: begin
          if (!waitrequest) begin
            if (msrc == 0) exp_ir = readdata;
            else if (!x_wr) exp_dr = readdata;
            else begin
              for (int b = 0; b < 4; b++)
                if (x_be[b]) mem[x_addr[9:2]][8*b +: 8] = x_wdata[8*b +: 8];
            end
            mphase = 2;
          end
        end
        default: mphase = 0;
      endcase
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t_done;
    logic [31:0] ld_val, st_hold;
    bit          saw_store, saw_ddone;
    int          exp_ord [6];
    exp_ord = '{1, 1, 0, 1, 1, 0};

    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    mphase = 0; msrc = 0; mk = 0; exp_ir = '0; exp_dr = '0;
    x_addr = '0; x_wdata = '0; x_wr = 1'b0; x_be = '0;
    req_mode = 2; force_wait = 0; rand_wait = 1'b0;
    reset = 1'b0; reset0 = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    new_fetch(); new_data();
    waitrequest = 1'b0; readdata = '0;

    // Reset held two cycles with both requests active
    @(negedge clk); cycle();
    chk("rst_address", address, 0);
    chk("rst_writedata", writedata, 0);
    @(negedge clk); cycle();
    @(negedge clk);
    reset = 1'b1; d_req = 1'b0; i_req = 1'b1; i_addr = 32'hBFC0_0003;
    cycle();
    @(negedge clk);
    chk("rel_read", rd, 1);
    chk("rel_address", address, 32'hBFC0_0000);
    cycle();
    repeat (4) begin @(negedge clk); cycle(); end

    // Load with three stall cycles
    mem[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_1004; d_byteenable = 4'hF;
    force_wait = 3;
    cycle();
    t_done = -1; ld_val = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (d_done && t_done < 0) begin t_done = n; ld_val = d_rdata; end
      cycle();
    end
    chk("load_done_cycle", t_done, 5);
    chk("load_rdata", ld_val, 32'hDEAD_BEEF);

    // Store
    @(negedge clk);
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0020;
    d_wdata = 32'h1234_5678; d_byteenable = 4'b0011;
    cycle();
    saw_store = 1'b0; saw_ddone = 1'b0; st_hold = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (wr && !rd && writedata == 32'h1234_5678 && byteenable == 4'b0011) saw_store = 1'b1;
      if (d_done) begin saw_ddone = 1'b1; st_hold = d_rdata; end
      cycle();
    end
    chk("store_strobe", saw_store, 1);
    chk("store_done", saw_ddone, 1);
    chk("store_rdata_hold", st_hold, 32'hDEAD_BEEF);

    // Starvation bound (STARVE_MAX=2) and fetch-first with STARVE_MAX=0
    @(negedge clk);
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    cycle();
    @(negedge clk);
    reset = 1'b1; reset0 = 1'b1;
    i_req = 1'b1; new_fetch(); d_req = 1'b1; new_data();
    req_mode = 1; obs.delete();
    cycle();
    @(negedge clk);
    chk("smax0_read", rd_z, 1);
    chk("smax0_write", wr_z, 0);
    chk("smax0_address", address_z, {i_addr[31:2], 2'b00});
    cycle();
    for (int n = 0; n < 120 && obs.size() < 6; n++) begin @(negedge clk); cycle(); end
    chk("starve_count", obs.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < obs.size()) chk($sformatf("starve_order%0d", k), obs[k], exp_ord[k]);

    // Randomized traffic with random stalls
    req_mode = 0; rand_wait = 1'b1;
    repeat (3000) begin @(negedge clk); cycle(); end

    // Reset in the middle of a stalled data transfer
    rand_wait = 1'b0; req_mode = 2;
    @(negedge clk);
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    cycle();
    @(negedge clk);
    reset = 1'b1; i_req = 1'b1; new_fetch(); d_req = 1'b1; new_data();
    req_mode = 1; obs.delete();
    cycle();
    for (int n = 0; n < 20 && obs.size() < 1; n++) begin @(negedge clk); cycle(); end
    force_wait = 20;
    for (int n = 0; n < 10 && mphase != 1; n++) begin @(negedge clk); cycle(); end
    @(negedge clk); cycle();
    @(negedge clk);
    reset = 1'b0;
    cycle();
    force_wait = 0;
    @(negedge clk);
    chk("midrst_write", wr, 0);
    chk("midrst_read", rd, 0);
    chk("midrst_d_done", d_done, 0);
    chk("midrst_busy", busy, 0);
    reset = 1'b1; obs.delete();
    cycle();
    for (int n = 0; n < 20 && obs.size() < 1; n++) begin @(negedge clk); cycle(); end
    chk("postrst_done", obs.size() > 0, 1);
    if (obs.size() > 0) chk("postrst_first_src", obs[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
